// File: rtl/csr_interrupt_unit.sv
// Machine-mode CSR file and interrupt controller for the EX stage: holds the
// trap CSRs, synchronises external interrupts and issues trap/return redirects.
module csr_interrupt_unit #(
  parameter int NUM_IRQ     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic               stall,
  input  logic               ecall_ex,
  input  logic               mret_ex,
  input  logic               csrrw_ex,
  input  logic               csrrsi_ex,
  input  logic               csrrci_ex,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  input  logic [4:0]         csr_uimm,
  input  logic [31:0]        pc_ex,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [31:0]        csr_rdata,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               flush,
  output logic [NUM_IRQ-1:0] int_ack
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  logic [0:0]         state;
  logic               mstatus_mie;
  logic               mstatus_mpie;
  logic [NUM_IRQ-1:0] mie_q;
  logic [31:0]        mtvec_q;
  logic [31:0]        mepc_q;
  logic [31:0]        mcause_q;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] edge_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] enabled;
  logic [NUM_IRQ-1:0] int_sel;
  logic [31:0]        int_cause;

  logic        active;
  logic        take_int;
  logic        do_ecall;
  logic        do_mret;
  logic        do_csr;
  logic [31:0] uimm_ext;
  logic [31:0] csr_new;

  // Read mux: always the pre-write value, so rd gets the old CSR contents.
  always_comb begin
    // NOTE: a default before the case keeps unmapped addresses at 0 and prevents a latch.
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      ADDR_MIE:     csr_rdata = {{(32-NUM_IRQ){1'b0}}, mie_q};
      ADDR_MTVEC:   csr_rdata = mtvec_q;
      ADDR_MEPC:    csr_rdata = mepc_q;
      ADDR_MCAUSE:  csr_rdata = mcause_q;
      default:      csr_rdata = '0;
    endcase
  end

  assign irq_rise = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign enabled  = pending & mie_q;

  // Lowest enabled index wins; the downward scan leaves it as the last assignment.
  always_comb begin
    int_sel   = '0;
    int_cause = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (enabled[i]) begin
        int_sel    = '0;
        int_sel[i] = 1'b1;
        int_cause  = 32'h8000_0010 + 32'(i);
      end
    end
  end

  assign active   = ~rst & (state == ST_RUN) & ~stall;
  assign take_int = active & ex_valid & mstatus_mie & (|enabled);
  assign do_ecall = active & ex_valid & ecall_ex & ~take_int;
  assign do_mret  = active & ex_valid & mret_ex & ~take_int & ~ecall_ex;
  assign do_csr   = active & ex_valid & (csrrw_ex | csrrsi_ex | csrrci_ex)
                    & ~take_int & ~ecall_ex & ~mret_ex;

  assign uimm_ext = {27'b0, csr_uimm};
  assign csr_new  = csrrw_ex  ? csr_wdata :
                    csrrsi_ex ? (csr_rdata | uimm_ext) :
                                (csr_rdata & ~uimm_ext);

  assign redirect    = take_int | do_ecall | do_mret;
  assign flush       = redirect;
  assign redirect_pc = do_mret ? mepc_q : (redirect ? mtvec_q : 32'h0);
  assign int_ack     = take_int ? int_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      edge_q  <= '0;
      pending <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values,
      // which is what turns this loop into a true shift chain.
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      edge_q  <= sync_q[SYNC_STAGES-1];
      // A fresh edge re-arms the line even when it is being acknowledged.
      pending <= (pending & ~int_ack) | irq_rise;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else begin
      if (take_int || do_ecall) begin
        mepc_q       <= pc_ex & ~32'h3;
        mcause_q     <= take_int ? int_cause : 32'd11;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (do_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (do_csr) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= csr_new[3];
            mstatus_mpie <= csr_new[7];
          end
          ADDR_MIE:    mie_q    <= csr_new[NUM_IRQ-1:0];
          ADDR_MTVEC:  mtvec_q  <= csr_new & ~32'h3;
          ADDR_MEPC:   mepc_q   <= csr_new & ~32'h3;
          ADDR_MCAUSE: mcause_q <= csr_new;
          default: ;
        endcase
      end

      // One dead cycle after every redirect; a stall freezes the FSM.
      if (redirect)                          state <= ST_REDIR;
      else if (state == ST_REDIR && !stall)  state <= ST_RUN;
    end
  end

endmodule

// File: tb/tb_csr_interrupt_unit.sv
// Self-checking bench for csr_interrupt_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a behavioural model.
module tb_csr_interrupt_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, stall = 1'b0;
  logic        ecall_ex = 1'b0, mret_ex = 1'b0;
  logic        csrrw_ex = 1'b0, csrrsi_ex = 1'b0, csrrci_ex = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [4:0]  csr_uimm = '0;
  logic [31:0] pc_ex = '0;
  logic [2:0]  irq_in = '0;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [2:0]  int_ack;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  csr_interrupt_unit #(.NUM_IRQ(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall),
    .ecall_ex(ecall_ex), .mret_ex(mret_ex), .csrrw_ex(csrrw_ex),
    .csrrsi_ex(csrrsi_ex), .csrrci_ex(csrrci_ex), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_uimm(csr_uimm), .pc_ex(pc_ex), .irq_in(irq_in),
    .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_mie_bit, m_mpie;
  bit [2:0]  m_mie;
  bit [31:0] m_mtvec, m_mepc, m_mcause;
  bit [2:0]  m_pend;
  bit        m_redir;
  bit [2:0]  irq_hist[$];   // index 0 = sample taken at the most recent edge

  function automatic void model_reset();
    m_mie_bit = 0; m_mpie = 0; m_mie = '0;
    m_mtvec = '0; m_mepc = '0; m_mcause = '0;
    m_pend = '0; m_redir = 0;
    irq_hist = '{3'b000, 3'b000, 3'b000};
  endfunction

  function automatic bit [31:0] model_read(input bit [11:0] a);
    case (a)
      12'h300: return (m_mie_bit ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h304: return {29'b0, m_mie};
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  // kind: 0 nothing, 1 interrupt, 2 ecall, 3 mret, 4 CSR write
  function automatic void model_eval(output bit e_red, output bit [31:0] e_pc,
                                     output bit [2:0] e_ack, output int kind,
                                     output bit [31:0] e_cause);
    e_red = 0; e_pc = '0; e_ack = '0; kind = 0; e_cause = '0;
    if (rst || m_redir || stall) return;
    if (ex_valid && m_mie_bit && ((m_pend & m_mie) != 0)) begin
      for (int i = 2; i >= 0; i--)
        if (m_pend[i] && m_mie[i]) begin
          e_ack = '0; e_ack[i] = 1'b1;
          e_cause = 32'h8000_0010 + 32'(i);
        end
      kind = 1; e_red = 1; e_pc = m_mtvec;
    end else if (ex_valid && ecall_ex) begin
      kind = 2; e_red = 1; e_pc = m_mtvec; e_cause = 32'd11;
    end else if (ex_valid && mret_ex) begin
      kind = 3; e_red = 1; e_pc = m_mepc;
    end else if (ex_valid && (csrrw_ex || csrrsi_ex || csrrci_ex)) begin
      kind = 4;
    end
  endfunction

  function automatic void model_csr_write();
    bit [31:0] old_v, new_v;
    old_v = model_read(csr_addr);
    if (csrrw_ex)       new_v = csr_wdata;
    else if (csrrsi_ex) new_v = old_v | {27'b0, csr_uimm};
    else                new_v = old_v & ~{27'b0, csr_uimm};
    case (csr_addr)
      12'h300: begin m_mie_bit = new_v[3]; m_mpie = new_v[7]; end
      12'h304: m_mie = new_v[2:0];
      12'h305: m_mtvec = new_v & ~32'h3;
      12'h341: m_mepc = new_v & ~32'h3;
      12'h342: m_mcause = new_v;
      default: ;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    bit e_red; bit [31:0] e_pc; bit [2:0] e_ack; int kind; bit [31:0] e_cause;
    bit [2:0] rise;
    if (rst) model_reset();
    else begin
      model_eval(e_red, e_pc, e_ack, kind, e_cause);
      // A line counts as newly raised when seen high two edges ago but low three edges ago.
      rise = irq_hist[1] & ~irq_hist[2];
      case (kind)
        1, 2: begin
          m_mepc = pc_ex & ~32'h3; m_mcause = e_cause;
          m_mpie = m_mie_bit; m_mie_bit = 0;
        end
        3: begin m_mie_bit = m_mpie; m_mpie = 1; end
        4: model_csr_write();
        default: ;
      endcase
      m_pend = (m_pend & ~e_ack) | rise;
      if (!stall) m_redir = e_red;
      irq_hist.push_front(irq_in);
      void'(irq_hist.pop_back());
    end
  end

  // Single compare process, sampled between edges.
  always @(negedge clk) begin
    bit e_red; bit [31:0] e_pc; bit [2:0] e_ack; int kind; bit [31:0] e_cause;
    #2;
    if (check_en) begin
      model_eval(e_red, e_pc, e_ack, kind, e_cause);
      check("m_redirect", {31'b0, redirect}, {31'b0, e_red});
      check("m_flush", {31'b0, flush}, {31'b0, e_red});
      check("m_int_ack", {29'b0, int_ack}, {29'b0, e_ack});
      if (e_red) check("m_redirect_pc", redirect_pc, e_pc);
      check("m_csr_rdata", csr_rdata, model_read(csr_addr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit ev, input bit st, input bit ec, input bit mr,
                       input bit rw, input bit rsi, input bit rci,
                       input logic [11:0] addr, input logic [31:0] wd,
                       input logic [4:0] ui, input logic [31:0] pc, input logic [2:0] irq);
    @(negedge clk);
    ex_valid = ev; stall = st; ecall_ex = ec; mret_ex = mr;
    csrrw_ex = rw; csrrsi_ex = rsi; csrrci_ex = rci;
    csr_addr = addr; csr_wdata = wd; csr_uimm = ui; pc_ex = pc; irq_in = irq;
    #3;
  endtask

  task automatic rd(input logic [11:0] addr);
    drive(0, 0, 0, 0, 0, 0, 0, addr, 32'h0, 5'h0, 32'h0, irq_in);
  endtask

  task automatic run_insn(input logic [31:0] pc, input logic [2:0] irq);
    drive(1, 0, 0, 0, 0, 0, 0, 12'h000, 32'h0, 5'h0, pc, irq);
  endtask

  logic [11:0] addr_tbl [7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h7C0, 12'h300};

  initial begin
    repeat (2) @(posedge clk);
    check_en = 1'b1;
    rd(12'h300);
    check("rst_redirect", {31'b0, redirect}, 32'h0);
    check("rst_int_ack", {29'b0, int_ack}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // CSR setup
    drive(1, 0, 0, 0, 1, 0, 0, 12'h305, 32'h100, 5'h0, 32'h0, 3'b000);
    check("mtvec_old", csr_rdata, 32'h0);
    drive(1, 0, 0, 0, 1, 0, 0, 12'h304, 32'h7, 5'h0, 32'h4, 3'b000);
    drive(1, 0, 0, 0, 0, 1, 0, 12'h300, 32'h0, 5'h8, 32'h8, 3'b000);
    check("mstatus_old", csr_rdata, 32'h0);
    rd(12'h300); check("mstatus_rd", csr_rdata, 32'h8);
    rd(12'h305); check("mtvec_rd", csr_rdata, 32'h100);

    // irq1 and irq2 rise together; irq1 wins after the synchroniser latency
    repeat (3) begin
      run_insn(32'h40, 3'b110);
      check("irq_latency_no_redirect", {31'b0, redirect}, 32'h0);
    end
    run_insn(32'h40, 3'b110);
    check("irq1_redirect", {31'b0, redirect}, 32'h1);
    check("irq1_pc", redirect_pc, 32'h100);
    check("irq1_ack", {29'b0, int_ack}, 32'h2);
    run_insn(32'h44, 3'b110);
    check("redir_quiet", {31'b0, redirect}, 32'h0);
    rd(12'h341); check("irq1_mepc", csr_rdata, 32'h40);
    rd(12'h342); check("irq1_mcause", csr_rdata, 32'h8000_0011);
    rd(12'h300); check("irq1_mstatus", csr_rdata, 32'h80);

    // mret, then the still-pending irq2 is taken right after the REDIR cycle
    drive(1, 0, 0, 1, 0, 0, 0, 12'h000, 32'h0, 5'h0, 32'h60, 3'b110);
    check("mret_redirect", {31'b0, redirect}, 32'h1);
    check("mret_pc", redirect_pc, 32'h40);
    run_insn(32'h40, 3'b110);
    check("mret_redir_quiet", {31'b0, int_ack}, 32'h0);
    run_insn(32'h40, 3'b110);
    check("irq2_ack", {29'b0, int_ack}, 32'h4);
    check("irq2_pc", redirect_pc, 32'h100);
    run_insn(32'h100, 3'b110);
    rd(12'h342); check("irq2_mcause", csr_rdata, 32'h8000_0012);

    // ecall while irq0 pending but MIE=0
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 12'h0, 32'h0, 5'h0, 32'h0, 3'b000);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 12'h0, 32'h0, 5'h0, 32'h0, 3'b001);
    drive(1, 0, 1, 0, 0, 0, 0, 12'h000, 32'h0, 5'h0, 32'h24, 3'b001);
    check("ecall_redirect", {31'b0, redirect}, 32'h1);
    check("ecall_pc", redirect_pc, 32'h100);
    check("ecall_no_ack", {29'b0, int_ack}, 32'h0);
    run_insn(32'h100, 3'b001);
    rd(12'h342); check("ecall_mcause", csr_rdata, 32'd11);
    rd(12'h341); check("ecall_mepc", csr_rdata, 32'h24);

    // enabling MIE applies to the next instruction, which then takes irq0
    drive(1, 0, 0, 0, 0, 1, 0, 12'h300, 32'h0, 5'h8, 32'h28, 3'b001);
    check("mie_set_same_cycle", {31'b0, redirect}, 32'h0);
    run_insn(32'h2C, 3'b001);
    check("irq0_ack", {29'b0, int_ack}, 32'h1);
    run_insn(32'h100, 3'b001);

    // edge arrives under a 5-cycle stall
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 12'h0, 32'h0, 5'h0, 32'h0, 3'b000);
    drive(1, 0, 0, 0, 0, 1, 0, 12'h300, 32'h0, 5'h8, 32'h30, 3'b000);
    repeat (5) begin
      drive(1, 1, 0, 0, 0, 0, 0, 12'h0, 32'h0, 5'h0, 32'h80, 3'b010);
      check("stall_no_redirect", {31'b0, redirect}, 32'h0);
    end
    run_insn(32'h80, 3'b010);
    check("post_stall_ack", {29'b0, int_ack}, 32'h2);
    run_insn(32'h100, 3'b010);

    // CSRRCI and unmapped address
    drive(1, 0, 0, 0, 0, 0, 1, 12'h304, 32'h0, 5'h1, 32'h104, 3'b010);
    check("csrrci_old", csr_rdata, 32'h7);
    rd(12'h304); check("csrrci_new", csr_rdata, 32'h6);
    drive(1, 0, 0, 0, 1, 0, 0, 12'h7C0, 32'hDEAD_BEEF, 5'h0, 32'h108, 3'b010);
    check("unmapped_old", csr_rdata, 32'h0);
    rd(12'h7C0); check("unmapped_rd", csr_rdata, 32'h0);

    // reset during REDIR
    drive(1, 0, 1, 0, 0, 0, 0, 12'h305, 32'h0, 5'h0, 32'h10C, 3'b010);
    check("ecall2_redirect", {31'b0, redirect}, 32'h1);
    run_insn(32'h100, 3'b010);
    rst = 1'b1;
    #1;
    check("rst_redir_redirect", {31'b0, redirect}, 32'h0);
    @(negedge clk); rst = 1'b0;
    drive(1, 0, 1, 0, 0, 0, 0, 12'h305, 32'h0, 5'h0, 32'h34, 3'b010);
    check("after_rst_ecall", {31'b0, redirect}, 32'h1);
    check("after_rst_pc", redirect_pc, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int op;
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      stall = ($urandom_range(0, 4) == 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 9);
      ecall_ex = (op == 0); mret_ex = (op == 1);
      csrrw_ex = (op == 2 || op == 3);
      csrrsi_ex = (op == 4 || op == 5);
      csrrci_ex = (op == 6);
      csr_addr = ($urandom_range(0, 15) == 0) ? 12'($urandom) : addr_tbl[$urandom_range(0, 6)];
      csr_wdata = $urandom;
      csr_uimm = 5'($urandom);
      pc_ex = $urandom;
      if ($urandom_range(0, 7) == 0) irq_in = 3'($urandom);
      #3;
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
